// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer write path.
//   FB_AW / FB_DW    default frame-buffer address and pixel widths
//   OWN_*            encoding of the arbiter's owner output
//   arb_state_t      arbiter FSM state encoding
//   src_t            identifies which engine last held the port
//   owner_of()       maps an arbiter state onto the owner encoding
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_AW = 20;
    localparam int FB_DW = 24;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PIC  = 2'd1;
    localparam logic [1:0] OWN_CR   = 2'd2;

    // The state codes equal the owner codes, so owner is a direct view of the
    // state register. Code 2'b11 is unused and recovers to ARB_IDLE.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_PIC = 2'd1,
        ARB_GNT_CR  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_PIC = 1'b0,
        SRC_CR  = 1'b1
    } src_t;

    function automatic logic [1:0] owner_of(input arb_state_t s);
        case (s)
            ARB_GNT_PIC: owner_of = OWN_PIC;
            ARB_GNT_CR:  owner_of = OWN_CR;
            default:     owner_of = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fb_wr_reg.sv
// -----------------------------------------------------------------------------
// fb_wr_reg
// Output register stage of the frame-buffer write arbiter. Captures the beat
// of whichever engine is being accepted this cycle and presents it on the FB
// write bus one cycle later.
//   clk, reset          clock; asynchronous active-high reset
//   sel_pic, sel_cr     one-hot: a PIC / CR beat is accepted this cycle
//   pic_addr, pic_data  PIC beat
//   cr_addr, cr_data    CR beat
//   fb_addr, fb_data    registered write address / pixel (held when idle)
//   fb_wen              registered write enable, one cycle per accepted beat
// -----------------------------------------------------------------------------
module fb_wr_reg
    import fb_pkg::*;
#(
    parameter int AW = FB_AW,
    parameter int DW = FB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sel_pic,
    input  logic          sel_cr,
    input  logic [AW-1:0] pic_addr,
    input  logic [DW-1:0] pic_data,
    input  logic [AW-1:0] cr_addr,
    input  logic [DW-1:0] cr_data,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_data,
    output logic          fb_wen
);

    // A reset drops any beat sitting in this register; the requester has to
    // present it again once the arbiter is back up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_wen  <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_wen <= sel_pic | sel_cr;
            if (sel_pic) begin
                fb_addr <= pic_addr;
                fb_data <= pic_data;
            end else if (sel_cr) begin
                fb_addr <= cr_addr;
                fb_data <= cr_data;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Shares the single frame-buffer write port between the picture drawer (PIC)
// and the clock renderer (CR). The port is granted in bursts with round-robin
// priority; a burst ends on a beat flagged last or after MAX_BURST beats,
// whichever comes first. Accepted beats reach the FB bus one cycle later.
//
// Handshake: x_req is "valid" and x_gnt is "ready". A beat transfers on every
// rising clock edge where x_req and x_gnt are both high. A requester keeps
// x_addr/x_data/x_last stable until its beat has transferred. Grants are
// decoded from the state register, so they never depend combinationally on
// the requests and at most one is high in any cycle.
//
// Ports
//   clk, reset                     clock; asynchronous active-high reset
//   pic_req/addr/data/last, pic_gnt   PIC beat channel and its grant
//   cr_req/addr/data/last,  cr_gnt    CR beat channel and its grant
//   fb_addr, fb_data, fb_wen       registered FB write port
//   owner                          0 none, 1 PIC, 2 CR; a view of the FSM state
//
// MAX_BURST is meaningful in the range 2..256.
// -----------------------------------------------------------------------------
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int AW        = FB_AW,
    parameter int DW        = FB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pic_req,
    input  logic [AW-1:0] pic_addr,
    input  logic [DW-1:0] pic_data,
    input  logic          pic_last,
    output logic          pic_gnt,
    input  logic          cr_req,
    input  logic [AW-1:0] cr_addr,
    input  logic [DW-1:0] cr_data,
    input  logic          cr_last,
    output logic          cr_gnt,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_data,
    output logic          fb_wen,
    output logic [1:0]    owner
);

    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    src_t             last_owner, last_owner_nxt;

    logic pic_acc;
    logic cr_acc;
    logic cap_hit;

    assign pic_gnt = (state == ARB_GNT_PIC);
    assign cr_gnt  = (state == ARB_GNT_CR);
    assign owner   = owner_of(state);

    assign pic_acc = pic_gnt & pic_req;
    assign cr_acc  = cr_gnt & cr_req;

    // The beat being accepted now is the MAX_BURST-th of this grant.
    assign cap_hit = (beat_cnt == CNT_CAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            beat_cnt   <= '0;
            last_owner <= SRC_PIC;    // CR wins the first tie after reset
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        beat_cnt_nxt   = beat_cnt;
        last_owner_nxt = last_owner;

        case (state)
            ARB_IDLE: begin
                if (pic_req && cr_req) begin
                    state_nxt = (last_owner == SRC_PIC) ? ARB_GNT_CR : ARB_GNT_PIC;
                end else if (pic_req) begin
                    state_nxt = ARB_GNT_PIC;
                end else if (cr_req) begin
                    state_nxt = ARB_GNT_CR;
                end
            end

            ARB_GNT_PIC: begin
                if (pic_req) begin
                    if (pic_last || cap_hit) begin
                        // Burst end. A last beat that also hits the cap is
                        // still a single burst end.
                        beat_cnt_nxt   = '0;
                        last_owner_nxt = SRC_PIC;
                        if (cr_req) begin
                            state_nxt = ARB_GNT_CR;
                        end else if (!pic_last) begin
                            state_nxt = ARB_GNT_PIC;   // cap hit, nobody waiting
                        end else begin
                            state_nxt = ARB_IDLE;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_ONE;
                    end
                end else if (cr_req) begin
                    // Owner stalled while the other engine waits: hand over.
                    beat_cnt_nxt   = '0;
                    last_owner_nxt = SRC_PIC;
                    state_nxt      = ARB_GNT_CR;
                end
            end

            ARB_GNT_CR: begin
                if (cr_req) begin
                    if (cr_last || cap_hit) begin
                        beat_cnt_nxt   = '0;
                        last_owner_nxt = SRC_CR;
                        if (pic_req) begin
                            state_nxt = ARB_GNT_PIC;
                        end else if (!cr_last) begin
                            state_nxt = ARB_GNT_CR;
                        end else begin
                            state_nxt = ARB_IDLE;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_ONE;
                    end
                end else if (pic_req) begin
                    beat_cnt_nxt   = '0;
                    last_owner_nxt = SRC_CR;
                    state_nxt      = ARB_GNT_PIC;
                end
            end

            default: begin
                state_nxt    = ARB_IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    fb_wr_reg #(
        .AW (AW),
        .DW (DW)
    ) u_wr_reg (
        .clk      (clk),
        .reset    (reset),
        .sel_pic  (pic_acc),
        .sel_cr   (cr_acc),
        .pic_addr (pic_addr),
        .pic_data (pic_data),
        .cr_addr  (cr_addr),
        .cr_data  (cr_data),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_wen   (fb_wen)
    );

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
// Bench for fb_write_arbiter (MAX_BURST=16, AW=20, DW=24). A reference model
// tracks who holds the port and how many beats the current grant has moved,
// and an expected queue carries each accepted beat to the FB bus one cycle
// later.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

    localparam int MAX_BURST = 16;
    localparam int AW        = 20;
    localparam int DW        = 24;

    // ------------------------------------------------------------ clock/reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          pic_req  = 1'b0;
    logic [AW-1:0] pic_addr = '0;
    logic [DW-1:0] pic_data = '0;
    logic          pic_last = 1'b0;
    logic          pic_gnt;
    logic          cr_req   = 1'b0;
    logic [AW-1:0] cr_addr  = '0;
    logic [DW-1:0] cr_data  = '0;
    logic          cr_last  = 1'b0;
    logic          cr_gnt;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic          fb_wen;
    logic [1:0]    owner;

    fb_write_arbiter #(
        .MAX_BURST (MAX_BURST),
        .AW        (AW),
        .DW        (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pic_req  (pic_req),
        .pic_addr (pic_addr),
        .pic_data (pic_data),
        .pic_last (pic_last),
        .pic_gnt  (pic_gnt),
        .cr_req   (cr_req),
        .cr_addr  (cr_addr),
        .cr_data  (cr_data),
        .cr_last  (cr_last),
        .cr_gnt   (cr_gnt),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_wen   (fb_wen),
        .owner    (owner)
    );

    int n_checks = 0;
    int n_errors = 0;

    // --------------------------------------------------------- reference model
    // m_owner: 0 nobody, 1 PIC, 2 CR. m_beats: beats moved in this burst.
    int                 m_owner;
    int                 m_last_owner;
    int                 m_beats;
    logic               m_wen;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_data;
    logic               m_acc_pic;
    logic               m_acc_cr;
    logic [AW+DW-1:0]   exp_q[$];

    task automatic model_reset();
        m_owner      = 0;
        m_last_owner = 1;
        m_beats      = 0;
        m_wen        = 1'b0;
        m_addr       = '0;
        m_data       = '0;
        m_acc_pic    = 1'b0;
        m_acc_cr     = 1'b0;
        exp_q.delete();
    endtask

    // Advance DUT and model across one rising edge; returns #1 after it.
    task automatic step();
        logic req [0:2];
        logic lst [0:2];
        int   x;
        int   o;
        int   nxt;
        req[0] = 1'b0; lst[0] = 1'b0;
        req[1] = pic_req; lst[1] = pic_last;
        req[2] = cr_req;  lst[2] = cr_last;
        m_acc_pic = (m_owner == 1) && pic_req;
        m_acc_cr  = (m_owner == 2) && cr_req;
        if (m_acc_pic) exp_q.push_back({pic_addr, pic_data});
        if (m_acc_cr)  exp_q.push_back({cr_addr, cr_data});
        nxt = m_owner;
        if (m_owner == 0) begin
            if (req[1] && req[2]) nxt = 3 - m_last_owner;
            else if (req[1])      nxt = 1;
            else if (req[2])      nxt = 2;
        end else begin
            x = m_owner;
            o = 3 - x;
            if (req[x]) begin
                m_beats++;
                if (lst[x] || m_beats == MAX_BURST) begin
                    m_beats      = 0;
                    m_last_owner = x;
                    nxt = req[o] ? o : (lst[x] ? 0 : x);
                end
            end else if (req[o]) begin
                m_beats      = 0;
                m_last_owner = x;
                nxt          = o;
            end
        end
        @(posedge clk);
        #1;
        m_owner = nxt;
        m_wen   = m_acc_pic || m_acc_cr;
        if (m_wen) {m_addr, m_data} = exp_q.pop_front();
    endtask

    // ---------------------------------------------------------------- drivers
    int            pic_idx, pic_len, cr_idx, cr_len;
    logic [AW-1:0] pic_base, cr_base;

    task automatic present();
        pic_addr = pic_base + AW'(pic_idx);
        pic_data = {4'h1, pic_addr};
        pic_last = (pic_len != 0) && (pic_idx == pic_len - 1);
        cr_addr  = cr_base + AW'(cr_idx);
        cr_data  = {4'h2, cr_addr};
        cr_last  = (cr_len != 0) && (cr_idx == cr_len - 1);
    endtask

    task automatic advance();
        if (m_acc_pic) pic_idx++;
        if (m_acc_cr)  cr_idx++;
        present();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        pic_req = 1'b0;
        cr_req  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        pic_idx = 0; pic_len = 0; pic_base = '0;
        cr_idx  = 0; cr_len  = 0; cr_base  = '0;
        present();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_async: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected all zero",
                     pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_held: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected all zero",
                     pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data);
        end
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL reset_idle cyc %0d: gnt=%b%b owner=%0d wen=%b, expected owner=%0d wen=%b",
                         c, pic_gnt, cr_gnt, owner, fb_wen, m_owner, m_wen);
            end
        end
    endtask

    task automatic test_pic_burst();
        int wen_cnt = 0;
        do_reset();
        pic_base = 20'h00100; pic_len = 4; pic_idx = 0;
        present();
        pic_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL pic_burst cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
            if (c == 0) begin
                n_checks++;
                if (pic_gnt !== 1'b1) begin
                    n_errors++;
                    $display("FAIL pic_grant_latency: pic_gnt=%b, expected 1", pic_gnt);
                end
            end
            if (fb_wen === 1'b1) wen_cnt++;
            advance();
            if (pic_idx == pic_len) pic_req = 1'b0;
        end
        n_checks++;
        if (wen_cnt != 4) begin
            n_errors++;
            $display("FAIL pic_burst_wen_count: got %0d, expected 4", wen_cnt);
        end
        n_checks++;
        if (owner !== 2'd0) begin
            n_errors++;
            $display("FAIL pic_burst_idle: owner=%0d, expected 0", owner);
        end
    endtask

    task automatic test_tie();
        int wen_cnt = 0;
        do_reset();
        pic_base = 20'h00200; pic_len = 3;
        cr_base  = 20'h00300; cr_len  = 2;
        present();
        pic_req = 1'b1;
        cr_req  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL tie cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
            if (c == 0) begin
                n_checks++;
                if ({pic_gnt, cr_gnt} !== 2'b01) begin
                    n_errors++;
                    $display("FAIL tie_first_grant: pic_gnt=%b cr_gnt=%b, expected CR first", pic_gnt, cr_gnt);
                end
            end
            if (fb_wen === 1'b1) wen_cnt++;
            advance();
            if (pic_idx == pic_len) pic_req = 1'b0;
            if (cr_idx == cr_len)   cr_req  = 1'b0;
        end
        n_checks++;
        if (wen_cnt != 5) begin
            n_errors++;
            $display("FAIL tie_wen_count: got %0d, expected 5", wen_cnt);
        end
    endtask

    task automatic test_continuous();
        int wen_cnt = 0;
        int drops   = 0;
        do_reset();
        pic_base = 20'h04000; pic_len = 0;
        present();
        pic_req = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL continuous cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
            if (pic_idx < 40 && pic_gnt !== 1'b1) drops++;
            if (fb_wen === 1'b1) wen_cnt++;
            advance();
            if (pic_idx == 40) pic_req = 1'b0;
        end
        n_checks++;
        if (drops != 0) begin
            n_errors++;
            $display("FAIL continuous_gnt_drops: got %0d, expected 0", drops);
        end
        n_checks++;
        if (wen_cnt != 40) begin
            n_errors++;
            $display("FAIL continuous_wen_count: got %0d, expected 40", wen_cnt);
        end
    endtask

    task automatic test_cap_preempt();
        int cr_at = -1;
        do_reset();
        pic_base = 20'h08000; pic_len = 0;
        cr_base  = 20'h0C000; cr_len  = 2;
        present();
        pic_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL cap_preempt cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
            n_checks++;
            if (pic_gnt === 1'b1 && cr_gnt === 1'b1) begin
                n_errors++;
                $display("FAIL cap_one_hot cyc %0d: pic_gnt=%b cr_gnt=%b, expected at most one", c, pic_gnt, cr_gnt);
            end
            advance();
            if (cr_gnt === 1'b1 && cr_at < 0) cr_at = pic_idx;
            if (pic_idx == 5 && cr_idx == 0) cr_req = 1'b1;
            if (cr_idx == cr_len) cr_req = 1'b0;
        end
        n_checks++;
        if (cr_at != MAX_BURST) begin
            n_errors++;
            $display("FAIL cap_switch_beat: PIC beats before cr_gnt=%0d, expected %0d", cr_at, MAX_BURST);
        end
    endtask

    task automatic test_stall_switch();
        int drop_c = -1;
        do_reset();
        pic_base = 20'h10000; pic_len = 0;
        cr_base  = 20'h20000; cr_len  = 2;
        present();
        pic_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL stall_switch cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
            if (drop_c >= 0 && c == drop_c + 1) begin
                n_checks++;
                if ({cr_gnt, fb_wen} !== 2'b10) begin
                    n_errors++;
                    $display("FAIL stall_handover: cr_gnt=%b fb_wen=%b, expected cr_gnt=1 fb_wen=0", cr_gnt, fb_wen);
                end
            end
            advance();
            if (pic_idx == 1 && cr_idx == 0) cr_req = 1'b1;
            if (pic_idx == 3 && drop_c < 0) begin
                pic_req = 1'b0;
                drop_c  = c;
            end
            if (cr_idx == cr_len) cr_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int cr_at = -1;
        do_reset();
        pic_base = 20'h30000; pic_len = 0;
        cr_base  = 20'h38000; cr_len  = 1;
        present();
        pic_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL reset_mid_pre cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
            advance();
            if (pic_idx == 7) break;
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_async: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected all zero",
                     pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        pic_idx = 0;
        present();
        // With CR waiting from the first beat, the switch must come after a
        // full MAX_BURST beats counted from the restart.
        for (int c = 0; c < 30; c++) begin
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL reset_mid_post cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
            advance();
            if (cr_gnt === 1'b1 && cr_at < 0) cr_at = pic_idx;
            if (pic_idx == 1 && cr_idx == 0) cr_req = 1'b1;
            if (cr_idx == cr_len) cr_req = 1'b0;
        end
        n_checks++;
        if (cr_at != MAX_BURST) begin
            n_errors++;
            $display("FAIL reset_mid_restart_count: PIC beats before cr_gnt=%0d, expected %0d", cr_at, MAX_BURST);
        end
    endtask

    task automatic test_random();
        int p_pct;
        int c_pct;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            p_pct = (c < 300) ? 75 : 90;
            c_pct = (c < 300) ? 75 : 8;
            pic_req  = ($urandom_range(0, 99) < p_pct);
            pic_last = ($urandom_range(0, 19) == 0);
            pic_addr = AW'($urandom);
            pic_data = DW'($urandom);
            cr_req   = ($urandom_range(0, 99) < c_pct);
            cr_last  = ($urandom_range(0, 19) == 0);
            cr_addr  = AW'($urandom);
            cr_data  = DW'($urandom);
            step();
            n_checks++;
            if ({pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data} !==
                {m_owner == 1, m_owner == 2, 2'(m_owner), m_wen, m_addr, m_data}) begin
                n_errors++;
                $display("FAIL random cyc %0d: gnt=%b%b owner=%0d wen=%b addr=%h data=%h, expected owner=%0d wen=%b addr=%h data=%h",
                         c, pic_gnt, cr_gnt, owner, fb_wen, fb_addr, fb_data, m_owner, m_wen, m_addr, m_data);
            end
        end
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        model_reset();
        pic_idx = 0; pic_len = 0; pic_base = '0;
        cr_idx  = 0; cr_len  = 0; cr_base  = '0;
        test_reset();
        test_pic_burst();
        test_tie();
        test_continuous();
        test_cap_preempt();
        test_stall_switch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
